// File: rtl/row_ctx_loader.sv
// Loads CTX_N PE-row contexts from a 32-bit config stream, then replays them
// as INIT/RUN sequences. Define ROW_CTX_LOOP_EN to add the `loop` input.
module row_ctx_loader #(
    parameter int CFG_W = 128,
    parameter int CTX_N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    input  logic [31:0]              cfg_data,
    output logic                     cfg_ready,
    input  logic                     start,
    input  logic                     reload,
`ifdef ROW_CTX_LOOP_EN
    input  logic                     loop,
`endif
    input  logic [15:0]              run_cycles,
    input  logic [$clog2(CTX_N):0]   ctx_count,
    output logic [CFG_W-1:0]         config_buffer,
    output logic                     init,
    output logic                     run,
    output logic                     busy,
    output logic                     done
);

    localparam int WORDS  = (CFG_W + 31) / 32;
    localparam int MEM_W  = WORDS * 32;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CTX_W  = (CTX_N > 1) ? $clog2(CTX_N) : 1;
    localparam int CNT_W  = $clog2(CTX_N) + 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_READY,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [WORD_W-1:0]  word_q,      word_d;
    logic [CTX_W-1:0]   ld_ctx_q,    ld_ctx_d;
    logic [CTX_W-1:0]   ctx_idx_q,   ctx_idx_d;
    logic [15:0]        run_cnt_q,   run_cnt_d;
    logic [15:0]        run_len_q,   run_len_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [CFG_W-1:0]   cfg_buf_q,   cfg_buf_d;
    logic               init_q,      init_d;
    logic               run_q,       run_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               cfg_ready_q, cfg_ready_d;

    logic [MEM_W-1:0]   ctx_mem [CTX_N];
    logic               mem_we;
    logic               run_last;
    logic               last_ctx;
    logic               loop_en;
    logic [CNT_W-1:0]   count_clamped;

    assign run_last      = ({1'b0, run_cnt_q} + 17'd1) >= {1'b0, run_len_q};
    assign last_ctx      = CNT_W'(ctx_idx_q) == (count_q - CNT_W'(1));
    assign count_clamped = (ctx_count > CNT_W'(CTX_N)) ? CNT_W'(CTX_N) : ctx_count;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d   = state_q;
        word_d    = word_q;
        ld_ctx_d  = ld_ctx_q;
        ctx_idx_d = ctx_idx_q;
        run_cnt_d = run_cnt_q;
        run_len_d = run_len_q;
        count_d   = count_q;
        cfg_buf_d = cfg_buf_q;
        mem_we    = 1'b0;
`ifdef ROW_CTX_LOOP_EN
        loop_en   = loop;
`else
        loop_en   = 1'b0;
`endif

        // reload wins over everything, including a word offered in the same cycle
        if (reload) begin
            state_d   = S_LOAD;
            word_d    = '0;
            ld_ctx_d  = '0;
            ctx_idx_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (cfg_valid) begin
                        mem_we = 1'b1;
                        if (word_q == WORD_W'(WORDS - 1)) begin
                            word_d = '0;
                            if (ld_ctx_q == CTX_W'(CTX_N - 1)) begin
                                ld_ctx_d = '0;
                                state_d  = S_READY;
                            end else begin
                                ld_ctx_d = ld_ctx_q + CTX_W'(1);
                            end
                        end else begin
                            word_d = word_q + WORD_W'(1);
                        end
                    end
                end
                S_READY: begin
                    if (start) begin
                        run_len_d = run_cycles;
                        count_d   = count_clamped;
                        ctx_idx_d = '0;
                        if (count_clamped == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_INIT;
                            cfg_buf_d = ctx_mem[0][CFG_W-1:0];
                        end
                    end
                end
                S_INIT: begin
                    state_d   = S_RUN;
                    run_cnt_d = '0;
                end
                S_RUN: begin
                    if (run_last) begin
                        if (last_ctx) begin
                            if (loop_en) begin
                                state_d   = S_INIT;
                                ctx_idx_d = '0;
                                cfg_buf_d = ctx_mem[0][CFG_W-1:0];
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            state_d   = S_INIT;
                            ctx_idx_d = ctx_idx_q + CTX_W'(1);
                            cfg_buf_d = ctx_mem[ctx_idx_q + CTX_W'(1)][CFG_W-1:0];
                        end
                    end else begin
                        run_cnt_d = run_cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_READY;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end

        // Strobes are registered images of the next state
        init_d      = (state_d == S_INIT);
        run_d       = (state_d == S_RUN);
        busy_d      = (state_d == S_INIT) || (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
        cfg_ready_d = (state_d == S_LOAD);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            word_q      <= '0;
            ld_ctx_q    <= '0;
            ctx_idx_q   <= '0;
            run_cnt_q   <= '0;
            run_len_q   <= '0;
            count_q     <= '0;
            cfg_buf_q   <= '0;
            init_q      <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            ld_ctx_q    <= ld_ctx_d;
            ctx_idx_q   <= ctx_idx_d;
            run_cnt_q   <= run_cnt_d;
            run_len_q   <= run_len_d;
            count_q     <= count_d;
            cfg_buf_q   <= cfg_buf_d;
            init_q      <= init_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // NOTE: context storage has no reset; reset forces LOAD, so stale data is never replayed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ctx_mem[ld_ctx_q][32*int'(word_q) +: 32] <= cfg_data;
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign config_buffer = cfg_buf_q;
    assign init          = init_q;
    assign run           = run_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_row_ctx_loader.sv
// Scoreboard bench for row_ctx_loader (CFG_W=128, CTX_N=2, loop feature off).
module tb_row_ctx_loader;

    localparam int CFG_W = 128;
    localparam int CTX_N = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [31:0]       cfg_data;
    logic              cfg_ready;
    logic              start;
    logic              reload;
    logic [15:0]       run_cycles;
    logic [1:0]        ctx_count;
    logic [CFG_W-1:0]  config_buffer;
    logic              init;
    logic              run;
    logic              busy;
    logic              done;

    row_ctx_loader #(.CFG_W(CFG_W), .CTX_N(CTX_N)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .start         (start),
        .reload        (reload),
        .run_cycles    (run_cycles),
        .ctx_count     (ctx_count),
        .config_buffer (config_buffer),
        .init          (init),
        .run           (run),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             init;
        logic             run;
        logic             done;
        logic [CFG_W-1:0] cb;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    logic [CFG_W-1:0] ctx_exp [CTX_N];
    logic [CFG_W-1:0] held_cb;

    task automatic check(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every cycle showing a strobe must match the next expected entry
    always @(negedge clk) begin
        if (init || run || done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual init=%b run=%b done=%b expected none", init, run, done);
            end else begin
                mon_e = sb_q.pop_front();
                if ({init, run, done, busy, config_buffer} !==
                    {mon_e.init, mon_e.run, mon_e.done, mon_e.init | mon_e.run, mon_e.cb}) begin
                    errors++;
                    $display("FAIL sb_compare actual i/r/d/b=%b%b%b%b cb=%h expected i/r/d/b=%b%b%b%b cb=%h",
                             init, run, done, busy, config_buffer,
                             mon_e.init, mon_e.run, mon_e.done, mon_e.init | mon_e.run, mon_e.cb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic i, input logic r, input logic d, input logic [CFG_W-1:0] cb);
        exp_t e;
        e.init = i;
        e.run  = r;
        e.done = d;
        e.cb   = cb;
        sb_q.push_back(e);
    endtask

    task automatic load_range(input logic [31:0] base, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check("cfg_ready_load", {127'd0, cfg_ready}, 1);
            cfg_valid = 1'b1;
            cfg_data  = base + 32'(i);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic set_ctx_exp(input logic [31:0] b);
        ctx_exp[0] = {b + 32'd3, b + 32'd2, b + 32'd1, b};
        ctx_exp[1] = {b + 32'd7, b + 32'd6, b + 32'd5, b + 32'd4};
    endtask

    // Expected sequence: per context one INIT then max(rc,1) RUN, then DONE
    task automatic run_job(input int rc, input int cc);
        int n;
        int r;
        int cyc;
        logic [CFG_W-1:0] last;
        n = (cc > CTX_N) ? CTX_N : cc;
        r = (rc == 0) ? 1 : rc;
        for (int c = 0; c < n; c++) begin
            push(1'b1, 1'b0, 1'b0, ctx_exp[c]);
            for (int k = 0; k < r; k++) push(1'b0, 1'b1, 1'b0, ctx_exp[c]);
        end
        last = (n == 0) ? held_cb : ctx_exp[n-1];
        push(1'b0, 1'b0, 1'b1, last);
        held_cb    = last;
        run_cycles = 16'(rc);
        ctx_count  = 2'(cc);
        start      = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
        end
        check("job_cycles", 128'(cyc), 128'(n * (1 + r) + 1));
        tick();
        check("job_idle_busy", {127'd0, busy}, 0);
        check("job_hold_cb", config_buffer, last);
        check("job_sb_empty", 128'(sb_q.size()), 0);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        start      = 1'b0;
        reload     = 1'b0;
        run_cycles = '0;
        ctx_count  = '0;
        held_cb    = '0;

        #12;
        check("rst_outputs", {config_buffer, init, run, busy, done}, 0);
        rst = 1'b0;
        tick();
        check("rst_cfg_ready", {127'd0, cfg_ready}, 1);

        // start while loading must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_in_load_busy", {127'd0, busy}, 0);

        load_range(32'h0, 0, 7);
        check("cfg_ready_after_load", {127'd0, cfg_ready}, 0);
        set_ctx_exp(32'h0);

        run_job(3, 2);
        run_job(0, 1);
        run_job(0, 0);
        run_job(1, 3);

        // Abort on the second RUN cycle
        push(1'b1, 1'b0, 1'b0, ctx_exp[0]);
        push(1'b0, 1'b1, 1'b0, ctx_exp[0]);
        push(1'b0, 1'b1, 1'b0, ctx_exp[0]);
        run_cycles = 16'd5;
        ctx_count  = 2'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("run_before_abort", {127'd0, run}, 1);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("abort_strobes", {126'd0, init, run}, 0);
        check("abort_busy", {127'd0, busy}, 0);
        check("abort_cfg_ready", {127'd0, cfg_ready}, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_start_ignored", {127'd0, busy}, 0);

        // reload with a simultaneous word: the word must be dropped
        cfg_valid = 1'b1;
        cfg_data  = 32'hdead_beef;
        reload    = 1'b1;
        tick();
        reload    = 1'b0;
        cfg_valid = 1'b0;
        load_range(32'h10, 0, 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("partial_start_ignored", {126'd0, busy, cfg_ready}, 1);
        load_range(32'h10, 7, 7);
        check("reload_cfg_ready_done", {127'd0, cfg_ready}, 0);
        set_ctx_exp(32'h10);
        check("abort_sb_empty", 128'(sb_q.size()), 0);
        held_cb = ctx_exp[0];
        run_job(1, 1);

        // Asynchronous reset in the middle of RUN
        push(1'b1, 1'b0, 1'b0, ctx_exp[0]);
        run_cycles = 16'd10;
        ctx_count  = 2'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("run_before_rst", {127'd0, run}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {config_buffer, init, run, busy, done}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_cfg_ready", {127'd0, cfg_ready}, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("post_rst_start_ignored", {127'd0, busy}, 0);
        check("final_sb_empty", 128'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
